// File: rtl/regfile_scoreboard.sv
// Register file with a per-register busy scoreboard.
// Ports: clock/ctrl_reset (sync, active high); one writeback port
// (ctrl_writeEnable, ctrl_writeReg, data_writeReg); two combinational
// read ports A/B (ctrl_readRegX -> data_readRegX, busy_readRegX); one
// reservation port (ctrl_reserveEnable, ctrl_reserveReg -> ctrl_reserveStall).

module regfile_scoreboard_rd #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 1,
   parameter int BYPASS     = 1
) (
   input  logic                  ctrl_reset,
   input  logic [ADDR_WIDTH-1:0] idx,
   input  logic [DATA_WIDTH-1:0] mem_data,
   input  logic                  mem_busy,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_idx,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_busy
);

   logic hit;
   logic zero;

   assign hit  = (BYPASS != 0) && wr_en && (wr_idx == idx);
   assign zero = (ZERO_REG != 0) && (idx == '0);

   always_comb begin
      rd_data = mem_data;
      rd_busy = mem_busy;
      // A same-cycle write forwards its data and its busy-clear.
      // A same-cycle reservation is never forwarded.
      if (hit) begin
         rd_data = wr_data;
         rd_busy = 1'b0;
      end
      // Zero register and reset dominate everything, bypass included.
      if (ctrl_reset || zero) begin
         rd_data = '0;
         rd_busy = 1'b0;
      end
   end

endmodule

module regfile_scoreboard #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 1,
   parameter int BYPASS     = 1
) (
   input  logic                  clock,
   input  logic                  ctrl_reset,
   input  logic                  ctrl_writeEnable,
   input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
   input  logic [DATA_WIDTH-1:0] data_writeReg,
   input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
   input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
   output logic [DATA_WIDTH-1:0] data_readRegA,
   output logic [DATA_WIDTH-1:0] data_readRegB,
   output logic                  busy_readRegA,
   output logic                  busy_readRegB,
   input  logic                  ctrl_reserveEnable,
   input  logic [ADDR_WIDTH-1:0] ctrl_reserveReg,
   output logic                  ctrl_reserveStall
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0]      busy;

   logic wr_zero;
   logic rs_zero;
   logic wr_ok;
   logic rs_ok;
   logic rs_same_wr;

   assign wr_zero    = (ZERO_REG != 0) && (ctrl_writeReg == '0);
   assign rs_zero    = (ZERO_REG != 0) && (ctrl_reserveReg == '0);
   assign rs_same_wr = ctrl_writeEnable
                       && (ctrl_writeReg == ctrl_reserveReg);

   // A write to the same index in the same cycle releases the entry,
   // so the reservation can be accepted instead of stalling.
   assign ctrl_reserveStall = !ctrl_reset
                              && ctrl_reserveEnable
                              && !rs_zero
                              && busy[ctrl_reserveReg]
                              && !rs_same_wr;

   assign wr_ok = !ctrl_reset && ctrl_writeEnable && !wr_zero;
   assign rs_ok = !ctrl_reset && ctrl_reserveEnable
                  && !rs_zero && !ctrl_reserveStall;

   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         busy <= '0;
      end else begin
         if (wr_ok) begin
            mem[ctrl_writeReg]  <= data_writeReg;
            busy[ctrl_writeReg] <= 1'b0;
         end
         // Placed after the write so a same-index reservation wins.
         if (rs_ok) begin
            busy[ctrl_reserveReg] <= 1'b1;
         end
      end
   end

   regfile_scoreboard_rd #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .ZERO_REG  (ZERO_REG),
      .BYPASS    (BYPASS)
   ) u_rd_a (
      .ctrl_reset(ctrl_reset),
      .idx       (ctrl_readRegA),
      .mem_data  (mem[ctrl_readRegA]),
      .mem_busy  (busy[ctrl_readRegA]),
      .wr_en     (ctrl_writeEnable),
      .wr_idx    (ctrl_writeReg),
      .wr_data   (data_writeReg),
      .rd_data   (data_readRegA),
      .rd_busy   (busy_readRegA)
   );

   regfile_scoreboard_rd #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .ZERO_REG  (ZERO_REG),
      .BYPASS    (BYPASS)
   ) u_rd_b (
      .ctrl_reset(ctrl_reset),
      .idx       (ctrl_readRegB),
      .mem_data  (mem[ctrl_readRegB]),
      .mem_busy  (busy[ctrl_readRegB]),
      .wr_en     (ctrl_writeEnable),
      .wr_idx    (ctrl_writeReg),
      .wr_data   (data_writeReg),
      .rd_data   (data_readRegB),
      .rd_busy   (busy_readRegB)
   );

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register data width in bits (1..64).
REQ-002 Parameter ADDR_WIDTH, default 5, register index width; DEPTH = 2**ADDR_WIDTH registers.
REQ-003 Parameter ZERO_REG, default 1, when 1 register 0 reads as zero, ignores writes and is never busy.
REQ-004 Parameter BYPASS, default 1, when 1 same-cycle write data and busy-clear are forwarded to read ports.
REQ-005 clock  input  1  sole clock; all state updates on rising edge.
REQ-006 ctrl_reset  input  1  synchronous, active-high reset.
REQ-007 ctrl_writeEnable  input  1  write strobe for writeback port.
REQ-008 ctrl_writeReg  input  ADDR_WIDTH  writeback register index.
REQ-009 data_writeReg  input  DATA_WIDTH  writeback data.
REQ-010 ctrl_readRegA / ctrl_readRegB  input  ADDR_WIDTH each  read port indices.
REQ-011 data_readRegA / data_readRegB  output  DATA_WIDTH each  read data, combinational.
REQ-012 busy_readRegA / busy_readRegB  output  1 each  scoreboard busy flag of the addressed register, combinational.
REQ-013 ctrl_reserveEnable  input  1  request to mark a destination register pending.
REQ-014 ctrl_reserveReg  input  ADDR_WIDTH  register index to reserve.
REQ-015 ctrl_reserveStall  output  1  combinational; 1 = reservation refused this cycle.

Function
REQ-016 Storage: DEPTH x DATA_WIDTH data registers plus DEPTH busy bits; no tristate buses, reads are mux-based.
REQ-017 Write: on a rising edge with ctrl_writeEnable=1 and ctrl_reset=0, reg[ctrl_writeReg] <= data_writeReg, and busy[ctrl_writeReg] <= 0 unless REQ-020 applies.
REQ-018 Reserve: on a rising edge with ctrl_reserveEnable=1, ctrl_reserveStall=0 and ctrl_reset=0, busy[ctrl_reserveReg] <= 1; data is unchanged.
REQ-019 Stall rule: ctrl_reserveStall = ctrl_reserveEnable AND busy[ctrl_reserveReg] AND NOT (ctrl_writeEnable AND ctrl_writeReg == ctrl_reserveReg); it is forced to 0 for the zero register and during reset.
REQ-020 A write and an accepted reservation to the same index in one cycle: data is written and the busy bit ends at 1 (reserve wins).
REQ-021 A stalled reservation changes no state; the requester holds its request, with no timeout.
REQ-022 Read latency is 0 cycles: data_readRegX = reg[ctrl_readRegX], busy_readRegX = busy[ctrl_readRegX].
REQ-023 With BYPASS=1, when ctrl_writeEnable=1 and ctrl_writeReg == ctrl_readRegX: data_readRegX = data_writeReg and busy_readRegX = 0; a same-cycle reservation is not forwarded.
REQ-024 With BYPASS=0, reads return pre-edge contents only.
REQ-025 With ZERO_REG=1, index 0 reads data 0 and busy 0, overriding bypass; writes and reservations to index 0 are dropped, and reserving index 0 never stalls.
REQ-026 Both read ports are independent and may address the same register or the write index simultaneously.
REQ-027 All index arithmetic is unsigned ADDR_WIDTH; no out-of-range indices exist.

Reset
REQ-028 On a rising edge with ctrl_reset=1, all data registers <= 0 and all busy bits <= 0; a same-cycle write or reservation is ignored.
REQ-029 While ctrl_reset=1, data_readRegA/B = 0, busy_readRegA/B = 0 and ctrl_reserveStall = 0.
REQ-030 Reset asserted mid-operation clears pending reservations; the first post-reset edge behaves as from power-up.

Verification
REQ-031 Reset, then read all 32 indices on A and B -> every data 0, every busy 0.
REQ-032 Write reg 7 = 0xDEADBEEF, read A=7 in the same cycle (BYPASS=1) -> data_readRegA=0xDEADBEEF; next cycle with writeEnable=0 -> still 0xDEADBEEF.
REQ-033 Reserve reg 3 -> busy_readRegB(3)=1 next cycle; reserve 3 again -> ctrl_reserveStall=1 and no change; same cycle plus write reg 3=0x55 -> stall=0, data 0x55, busy stays 1.
REQ-034 Write reg 0 = 0xFFFFFFFF and reserve reg 0 (ZERO_REG=1) -> data_readRegA(0)=0, busy 0, stall 0.
REQ-035 Reserve reg 9, write reg 9=0x1234 two cycles later -> busy_readRegA(9)=1 until the write cycle, 0 in the write cycle via bypass and after; data 0x1234.
REQ-036 Reserve reg 12 and write reg 12=0xAA, assert ctrl_reset the next cycle -> all reads 0, busy 0; post-reset reserve 12 -> stall 0.
